// File: rtl/discrete_sched_pkg.sv
// Shared types, widths and helpers for the discrete-circuit step scheduler.
// Node count, term count and widths live here so every file agrees on them.
package discrete_sched_pkg;

    localparam int NUM_CH    = 4;
    localparam int NUM_TERMS = 4;
    localparam int STATE_W   = 17;
    localparam int COEF_W    = 16;
    localparam int FRAC      = 12;

    localparam int IN_TERMS  = NUM_TERMS - 1;
    localparam int PROD_W    = COEF_W + STATE_W;
    localparam int ACC_W     = PROD_W + $clog2(NUM_TERMS);
    localparam int ADDR_W    = $clog2(NUM_CH * NUM_TERMS);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W       = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int SLOT_W    = (NUM_CH * IN_TERMS > 1) ? $clog2(NUM_CH * IN_TERMS) : 1;

    localparam logic signed [STATE_W-1:0] STATE_MAX = {1'b0, {(STATE_W-1){1'b1}}};
    localparam logic signed [STATE_W-1:0] STATE_MIN = {1'b1, {(STATE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } sched_state_t;

    // Arithmetic shift drops the fraction (rounds toward -inf), then clamp
    // to the signed node-state range if any discarded high bit disagrees
    // with the sign.
    function automatic logic signed [STATE_W-1:0] shift_saturate(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> FRAC;
        if ((&shifted[ACC_W-1:STATE_W-1]) || (~|shifted[ACC_W-1:STATE_W-1]))
            return shifted[STATE_W-1:0];
        else if (shifted[ACC_W-1])
            return STATE_MIN;
        else
            return STATE_MAX;
    endfunction

endpackage

// File: rtl/discrete_mac.sv
// Shared multiply-accumulate: one registered signed product per enabled
// cycle, folded into a wide accumulator on the following cycle.
module discrete_mac
    import discrete_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [STATE_W-1:0] operand,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod;
    logic                     prod_vld;

    // Register the product, then add it into the accumulator one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= en;
            if (en)
                prod <= PROD_W'(coef) * PROD_W'(operand);
            if (clear)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/discrete_step_scheduler.sv
// Time-multiplexes one MAC across all nodes each sample tick: per node it
// issues NUM_TERMS products, drains the pipeline, writes back the shifted
// and saturated sum, and finally publishes every node state at once.
module discrete_step_scheduler
    import discrete_sched_pkg::*;
(
    input  logic                                  clk_msdsl,
    input  logic                                  rst_msdsl,
    input  logic                                  tick,
    input  logic [NUM_CH*IN_TERMS*STATE_W-1:0]    in_data,
    input  logic                                  cfg_we,
    input  logic [ADDR_W-1:0]                     cfg_addr,
    input  logic [COEF_W-1:0]                     cfg_data,
    output logic                                  cfg_ready,
    input  logic                                  clr_overrun,
    output logic [NUM_CH*STATE_W-1:0]             state_out,
    output logic                                  out_valid,
    output logic                                  busy,
    output logic                                  overrun
);

    sched_state_t              fsm;
    logic [CH_W-1:0]           ch;
    logic [K_W-1:0]            k;
    logic signed [COEF_W-1:0]  coef_mem   [NUM_CH*NUM_TERMS];
    logic signed [STATE_W-1:0] node_state [NUM_CH];
    logic signed [STATE_W-1:0] snap       [NUM_CH*IN_TERMS];

    logic                      mac_en;
    logic                      mac_clear;
    logic [ADDR_W-1:0]         coef_idx;
    logic [SLOT_W-1:0]         slot_idx;
    logic signed [COEF_W-1:0]  sel_coef;
    logic signed [STATE_W-1:0] sel_x;
    logic signed [ACC_W-1:0]   acc;

    assign cfg_ready = !busy;

    // Pick this cycle's coefficient and operand; term 0 feeds back the node's own state.
    always_comb begin
        mac_en    = (fsm == S_MAC);
        mac_clear = ((fsm == S_IDLE) && tick) || (fsm == S_WRITE);
        coef_idx  = ADDR_W'(ch) * ADDR_W'(NUM_TERMS) + ADDR_W'(k);
        slot_idx  = SLOT_W'(ch) * SLOT_W'(IN_TERMS) + SLOT_W'(k) - SLOT_W'(1);
        sel_coef  = coef_mem[coef_idx];
        if (k == '0)
            sel_x = node_state[ch];
        else
            sel_x = snap[slot_idx];
    end

    discrete_mac u_mac (
        .clk     (clk_msdsl),
        .rst     (rst_msdsl),
        .clear   (mac_clear),
        .en      (mac_en),
        .coef    (sel_coef),
        .operand (sel_x),
        .acc     (acc)
    );

    // Sequencer, coefficient file, node states, snapshot and status flags.
    always_ff @(posedge clk_msdsl) begin
        if (rst_msdsl) begin
            fsm       <= S_IDLE;
            ch        <= '0;
            k         <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            state_out <= '0;
            for (int i = 0; i < NUM_CH*NUM_TERMS; i++)
                coef_mem[i] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                node_state[c] <= '0;
            for (int i = 0; i < NUM_CH*IN_TERMS; i++)
                snap[i] <= '0;
        end else begin
            out_valid <= 1'b0;

            if (cfg_we && !busy)
                coef_mem[cfg_addr] <= cfg_data;

            if (tick && busy)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            case (fsm)
                S_IDLE: begin
                    if (tick) begin
                        for (int i = 0; i < NUM_CH*IN_TERMS; i++)
                            snap[i] <= in_data[i*STATE_W +: STATE_W];
                        ch   <= '0;
                        k    <= '0;
                        busy <= 1'b1;
                        fsm  <= S_MAC;
                    end
                end
                S_MAC: begin
                    k <= k + K_W'(1);
                    if (k == K_W'(NUM_TERMS-1))
                        fsm <= S_DRAIN;
                end
                S_DRAIN: begin
                    fsm <= S_WRITE;
                end
                S_WRITE: begin
                    node_state[ch] <= shift_saturate(acc);
                    k <= '0;
                    if (ch == CH_W'(NUM_CH-1)) begin
                        fsm <= S_DONE;
                    end else begin
                        ch  <= ch + CH_W'(1);
                        fsm <= S_MAC;
                    end
                end
                S_DONE: begin
                    for (int c = 0; c < NUM_CH; c++)
                        state_out[c*STATE_W +: STATE_W] <= node_state[c];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    fsm       <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_step_scheduler.sv
// Self-checking bench for discrete_step_scheduler: a behavioural model
// predicts each sample's node states, expectations are queued at tick time
// and compared (values and latency) whenever out_valid fires.
module tb_discrete_step_scheduler;

    localparam int NCH   = 4;
    localparam int NT    = 4;
    localparam int IN_T  = NT - 1;
    localparam int SW    = 17;
    localparam int CW    = 16;
    localparam int FR    = 12;
    localparam int LAT   = NCH * (NT + 2) + 1;
    localparam longint SAT_MAX = (longint'(1) <<< (SW-1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (SW-1));

    logic                     clk_msdsl = 1'b0;
    logic                     rst_msdsl;
    logic                     tick;
    logic [NCH*IN_T*SW-1:0]   in_data;
    logic                     cfg_we;
    logic [3:0]               cfg_addr;
    logic [CW-1:0]            cfg_data;
    logic                     cfg_ready;
    logic                     clr_overrun;
    logic [NCH*SW-1:0]        state_out;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;

    always #5 clk_msdsl = ~clk_msdsl;

    discrete_step_scheduler dut (
        .clk_msdsl   (clk_msdsl),
        .rst_msdsl   (rst_msdsl),
        .tick        (tick),
        .in_data     (in_data),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .clr_overrun (clr_overrun),
        .state_out   (state_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct {
        logic [NCH*SW-1:0] vec;
        int                accept_edge;
    } exp_t;

    typedef struct {
        int in0;
        int in1;
        int in2;
        int exp0;
        int exp1;
        int exp2;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];

    int checks          = 0;
    int fails           = 0;
    int edge_count      = 0;
    int valid_count     = 0;
    int exp_valid_count = 0;

    int m_coef  [NCH*NT];
    int m_state [NCH];
    int m_in    [NCH][IN_T];

    always @(posedge clk_msdsl) edge_count <= edge_count + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint chOut(input int c);
        logic signed [SW-1:0] s;
        s = state_out[c*SW +: SW];
        return longint'(s);
    endfunction

    // Reference model: sum of coef*operand, floor-shift by FR, clamp.
    function automatic logic [NCH*SW-1:0] modelSample();
        logic [NCH*SW-1:0] v;
        longint acc;
        longint sh;
        int nxt [NCH];
        for (int c = 0; c < NCH; c++) begin
            acc = longint'(m_coef[c*NT]) * longint'(m_state[c]);
            for (int k = 1; k < NT; k++)
                acc += longint'(m_coef[c*NT+k]) * longint'(m_in[c][k-1]);
            sh = acc >>> FR;
            if (sh > SAT_MAX) sh = SAT_MAX;
            if (sh < SAT_MIN) sh = SAT_MIN;
            nxt[c] = int'(sh);
        end
        for (int c = 0; c < NCH; c++) begin
            m_state[c] = nxt[c];
            v[c*SW +: SW] = SW'(nxt[c]);
        end
        return v;
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < NCH*NT; i++) m_coef[i] = 0;
        for (int c = 0; c < NCH; c++) begin
            m_state[c] = 0;
            for (int k = 0; k < IN_T; k++) m_in[c][k] = 0;
        end
    endfunction

    task automatic applyStimulus();
        exp_t e;
        @(negedge clk_msdsl);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < IN_T; k++)
                in_data[(c*IN_T+k)*SW +: SW] = SW'(m_in[c][k]);
        tick = 1'b1;
        e.accept_edge = edge_count + 1;
        e.vec = modelSample();
        sb_q.push_back(e);
        exp_valid_count++;
        @(negedge clk_msdsl);
        tick = 1'b0;
    endtask

    task automatic scrambleInputs();
        for (int i = 0; i < NCH*IN_T; i++)
            in_data[i*SW +: SW] = SW'($urandom);
    endtask

    task automatic writeCoef(input int addr, input int data, input bit expect_accept);
        @(negedge clk_msdsl);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = CW'(data);
        checkOutput($sformatf("cfg_ready_at_write_%0d", addr), longint'(cfg_ready), longint'(expect_accept));
        @(negedge clk_msdsl);
        cfg_we = 1'b0;
        if (expect_accept) m_coef[addr] = data;
    endtask

    task automatic pulseTick(input bit clr);
        @(negedge clk_msdsl);
        tick        = 1'b1;
        clr_overrun = clr;
        @(negedge clk_msdsl);
        tick        = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic waitForOutput();
        for (int i = 0; i < 3*LAT && sb_q.size() != 0; i++)
            @(negedge clk_msdsl);
        if (sb_q.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL out_valid_timeout: got no pulse, expected %0d pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Scoreboard: every out_valid must match the oldest queued prediction.
    always @(negedge clk_msdsl) begin
        if (!rst_msdsl && out_valid) begin
            exp_t e;
            valid_count++;
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_out_valid: got pulse at edge %0d, expected none", edge_count);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sb_latency", longint'(edge_count - e.accept_edge), longint'(LAT));
                for (int c = 0; c < NCH; c++) begin
                    logic signed [SW-1:0] want;
                    want = e.vec[c*SW +: SW];
                    checkOutput($sformatf("sb_ch%0d", c), chOut(c), longint'(want));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_msdsl   = 1'b1;
        tick        = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        clr_overrun = 1'b0;
        in_data     = '0;
        clearModel();

        vecs[0] = '{in0: 1000, in1: 4096, in2: 0,      exp0: 1000, exp1: 4096, exp2: 0};
        vecs[1] = '{in0: 1000, in1: 0,    in2: 65535,  exp0: 1000, exp1: 2048, exp2: 65535};
        vecs[2] = '{in0: 0,    in1: 0,    in2: -65536, exp0: 0,    exp1: 1024, exp2: -65536};
        vecs[3] = '{in0: -7,   in1: 0,    in2: 3,      exp0: -7,   exp1: 512,  exp2: 23};
        vecs[4] = '{in0: 5,    in1: -100, in2: -1,     exp0: 5,    exp1: 156,  exp2: -8};

        repeat (3) @(negedge clk_msdsl);
        rst_msdsl = 1'b0;
        repeat (10) @(negedge clk_msdsl);
        checkOutput("reset_state_out", longint'(|state_out), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_cfg_ready", longint'(cfg_ready), 1);
        checkOutput("reset_overrun", longint'(overrun), 0);
        checkOutput("reset_no_valid", longint'(valid_count), 0);

        $display("[TB] pass-through");
        writeCoef(1, 4096, 1'b1);
        m_in[0][0] = 1000;
        applyStimulus();
        waitForOutput();
        checkOutput("pass_ch0", chOut(0), 1000);
        for (int c = 1; c < NCH; c++)
            checkOutput($sformatf("pass_ch%0d", c), chOut(c), 0);

        $display("[TB] vector table: decay, saturation, rounding");
        writeCoef(4, 2048, 1'b1);
        writeCoef(5, 4096, 1'b1);
        writeCoef(9, 32767, 1'b1);
        for (int v = 0; v < 5; v++) begin
            m_in[0][0] = vecs[v].in0;
            m_in[1][0] = vecs[v].in1;
            m_in[2][0] = vecs[v].in2;
            applyStimulus();
            scrambleInputs();
            waitForOutput();
            checkOutput($sformatf("vec%0d_ch0", v), chOut(0), vecs[v].exp0);
            checkOutput($sformatf("vec%0d_ch1", v), chOut(1), vecs[v].exp1);
            checkOutput($sformatf("vec%0d_ch2", v), chOut(2), vecs[v].exp2);
        end

        $display("[TB] overrun");
        m_in[0][0] = 1000;
        m_in[1][0] = 0;
        m_in[2][0] = 0;
        applyStimulus();
        repeat (8) @(negedge clk_msdsl);
        pulseTick(1'b0);
        checkOutput("overrun_set", longint'(overrun), 1);
        waitForOutput();
        checkOutput("overrun_result_ch0", chOut(0), 1000);
        repeat (2*LAT) @(negedge clk_msdsl);
        checkOutput("overrun_single_valid", longint'(valid_count), longint'(exp_valid_count));
        applyStimulus();
        repeat (5) @(negedge clk_msdsl);
        pulseTick(1'b1);
        checkOutput("overrun_set_wins", longint'(overrun), 1);
        waitForOutput();
        @(negedge clk_msdsl);
        clr_overrun = 1'b1;
        @(negedge clk_msdsl);
        clr_overrun = 1'b0;
        checkOutput("overrun_cleared", longint'(overrun), 0);

        $display("[TB] config while busy");
        applyStimulus();
        repeat (3) @(negedge clk_msdsl);
        writeCoef(1, 0, 1'b0);
        waitForOutput();
        applyStimulus();
        waitForOutput();
        checkOutput("busy_cfg_dropped_ch0", chOut(0), 1000);

        $display("[TB] reset mid-run");
        applyStimulus();
        repeat (10) @(negedge clk_msdsl);
        rst_msdsl = 1'b1;
        sb_q.delete();
        exp_valid_count--;
        clearModel();
        @(negedge clk_msdsl);
        rst_msdsl = 1'b0;
        checkOutput("midrst_busy", longint'(busy), 0);
        checkOutput("midrst_state_out", longint'(|state_out), 0);
        checkOutput("midrst_cfg_ready", longint'(cfg_ready), 1);
        repeat (2*LAT) @(negedge clk_msdsl);
        checkOutput("midrst_no_valid", longint'(valid_count), longint'(exp_valid_count));

        writeCoef(1, 4096, 1'b1);
        m_in[0][0] = 1000;
        m_in[1][0] = 4096;
        applyStimulus();
        waitForOutput();
        checkOutput("post_reset_ch0", chOut(0), 1000);
        checkOutput("post_reset_ch1", chOut(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
